// File: rtl/countdown_timer_16bit.sv
// countdown_timer_16bit: prescaled 16-bit down-counter with terminal-count pulse and optional auto-reload
module countdown_timer_16bit #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] count_n, reload_reg, reload_n;
  logic [PRE_W-1:0] pre_cnt, pre_n;
  logic tc_n;
  logic tick;
  assign tick = state == RUN && enable && pre_cnt == prescale;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      reload_reg <= '0;
      pre_cnt <= '0;
      tc <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      reload_reg <= reload_n;
      pre_cnt <= pre_n;
      tc <= tc_n;
    end
  end
  always_comb begin
    state_n = state;
    count_n = count;
    reload_n = reload_reg;
    pre_n = pre_cnt;
    tc_n = 1'b0;
    if (load) begin
      count_n = load_value;
      reload_n = load_value;
      pre_n = '0;
      state_n = load_value != '0 ? RUN : EXPIRED;
    end else if (state == RUN && enable) begin
      pre_n = tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick && count > WIDTH'(1)) count_n = count - WIDTH'(1);
      else if (tick) begin
        // expiry: reload in the same edge so the period has no extra cycle
        tc_n = 1'b1;
        count_n = auto_reload ? reload_reg : '0;
        state_n = auto_reload ? RUN : EXPIRED;
      end
    end
  end
  assign running = state == RUN;
  assign done = state == EXPIRED;
endmodule

// File: tb/tb_countdown_timer_16bit.sv
// tb_countdown_timer_16bit: vector table, corner sequences and random stimulus against a reference model
module tb_countdown_timer_16bit;
  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, load = 1'b0, auto_reload = 1'b0;
  logic [15:0] load_value = '0;
  logic [7:0] prescale = '0;
  logic [15:0] count;
  logic tc, running, done;
  int n_tests = 0, n_fail = 0;
  int m_count = 0, m_reload = 0, m_pre = 0, m_state = 0, m_tc = 0;

  countdown_timer_16bit dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .auto_reload(auto_reload), .prescale(prescale), .count(count), .tc(tc),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, en, ld, ar;
    logic [15:0] lv;
    logic [7:0] ps;
    int ec, etc, er, ed;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit en, bit ld, bit ar, int lv, int ps, int ec, int etc, int er, int ed);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.ar = ar; v.lv = 16'(lv); v.ps = 8'(ps);
    v.ec = ec; v.etc = etc; v.er = er; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state 0=idle, 1=running, 2=expired; applied to the inputs seen at the edge
  task automatic model_step();
    if (reset) begin
      m_count = 0; m_reload = 0; m_pre = 0; m_state = 0; m_tc = 0;
    end else if (load) begin
      m_count = load_value; m_reload = load_value; m_pre = 0; m_tc = 0;
      m_state = (load_value != 0) ? 1 : 2;
    end else begin
      m_tc = 0;
      if (m_state == 1 && enable) begin
        if (m_pre == int'(prescale)) begin
          m_pre = 0;
          if (m_count > 1) m_count = m_count - 1;
          else begin
            m_tc = 1;
            if (auto_reload) m_count = m_reload;
            else begin m_count = 0; m_state = 2; end
          end
        end else m_pre = (m_pre + 1) % 256;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("model_count", int'(count), m_count);
    chk("model_tc", int'(tc), m_tc);
    chk("model_running", int'(running), int'(m_state == 1));
    chk("model_done", int'(done), int'(m_state == 2));
  endtask

  initial begin
    int tcs, prev;
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 5, 0, 5, 0, 1, 0));
    for (int c = 4; c >= 1; c--) tbl.push_back(mk(0, 1, 0, 0, 5, 0, c, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5, 0, 0, 1, 0, 1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, 0, 0, 5, 0, 0, 0, 0, 1));
    foreach (tbl[i]) begin
      reset = tbl[i].rst; enable = tbl[i].en; load = tbl[i].ld; auto_reload = tbl[i].ar;
      load_value = tbl[i].lv; prescale = tbl[i].ps;
      step();
      chk("tbl_count", int'(count), tbl[i].ec);
      chk("tbl_tc", int'(tc), tbl[i].etc);
      chk("tbl_running", int'(running), tbl[i].er);
      chk("tbl_done", int'(done), tbl[i].ed);
    end

    // auto-reload: 3 ticks of 3 cycles, tc every 9 cycles
    load = 1; load_value = 3; prescale = 2; auto_reload = 1; enable = 1;
    step();
    load = 0; tcs = 0;
    for (int i = 1; i <= 36; i++) begin
      step();
      chk("ar_count", int'(count), 3 - (i % 9) / 3);
      chk("ar_tc", int'(tc), int'(i % 9 == 0));
      tcs += int'(tc);
    end
    chk("ar_pulses", tcs, 4);

    // enable toggled every other cycle
    load = 1; load_value = 4; prescale = 0; auto_reload = 0; enable = 0;
    step();
    load = 0; prev = int'(count);
    for (int i = 1; i <= 10; i++) begin
      enable = (i % 2 == 0);
      step();
      if (!enable) chk("en_frozen", int'(count), prev);
      chk("en_tc", int'(tc), int'(i == 8));
      prev = int'(count);
    end

    // load coinciding with the expiry tick, then a zero load
    enable = 1; load = 1; load_value = 2;
    step();
    load = 0;
    step();
    chk("pre_exp_count", int'(count), 1);
    load = 1; load_value = 16'h1234;
    step();
    chk("ldexp_count", int'(count), 16'h1234);
    chk("ldexp_tc", int'(tc), 0);
    chk("ldexp_running", int'(running), 1);
    load_value = 0;
    step();
    chk("ld0_done", int'(done), 1);
    chk("ld0_tc", int'(tc), 0);
    chk("ld0_running", int'(running), 0);
    load = 0;

    // reset mid-count and on a tc cycle
    load = 1; load_value = 7; prescale = 3;
    step();
    load = 0;
    step();
    chk("pre_rst_count", int'(count), 7);
    reset = 1;
    step();
    chk("rst_run_count", int'(count), 0);
    chk("rst_run_running", int'(running), 0);
    reset = 0; load = 1; load_value = 2; prescale = 0;
    step();
    load = 0;
    step();
    step();
    chk("pre_rst_tc", int'(tc), 1);
    reset = 1;
    step();
    chk("rst_tc_tc", int'(tc), 0);
    chk("rst_tc_done", int'(done), 0);
    reset = 0;

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 39) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      enable = ($urandom_range(0, 4) != 0);
      auto_reload = 1'($urandom);
      if ($urandom_range(0, 29) == 0) prescale = 8'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/countdown_timer_16bit.md
# countdown_timer_16bit

Programmable 16-bit down-counter: the decrementing counterpart to the team's 16-bit up-counter feature design, used as a post-synthesis sequential test target on qlf_k4n8. It loads a start value, counts down on prescaled enable ticks, and pulses a terminal-count flag on reaching zero. It either stops or auto-reloads. The block is a top-level test design with registered outputs, suitable for SDF-annotated gate-level simulation.

## Interface
- WIDTH, 16, counter and load-value width
- PRE_W, 8, prescaler width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clock clk
- enable  input  1  count enable; low freezes counter and prescaler
- load  input  1  one-cycle strobe: capture load_value and start
- load_value  input  WIDTH  start / reload value
- auto_reload  input  1  1 = reload on expiry, 0 = stop at zero
- prescale  input  PRE_W  tick every prescale+1 enabled cycles
- count  output  WIDTH  current counter value (registered)
- tc  output  1  one-cycle terminal-count pulse (registered)
- running  output  1  high in RUN state
- done  output  1  high in EXPIRED state

## Operation
- Internal registers: state {IDLE, RUN, EXPIRED}, reload_reg[WIDTH], pre_cnt[PRE_W].
- Reset values: count=0, tc=0, running=0, done=0, state=IDLE, reload_reg=0, pre_cnt=0.
- Priority per edge: reset > load > tick.
- load=1, any state:
  - count<=load_value, reload_reg<=load_value, pre_cnt<=0, tc<=0.
  - State<=RUN if load_value!=0.
  - State<=EXPIRED if load_value==0; no tc pulse.
- IDLE: everything holds; only load leaves.
- RUN, enable=0: count, pre_cnt hold; tc<=0.
- RUN, enable=1, pre_cnt!=prescale: pre_cnt<=pre_cnt+1, count holds.
- RUN, enable=1, pre_cnt==prescale: tick; pre_cnt<=0.
  - count>1: count<=count-1.
  - count==1, auto_reload=1: tc<=1, count<=reload_reg, stay RUN.
  - count==1, auto_reload=0: tc<=1, count<=0, state<=EXPIRED.
- EXPIRED: count holds 0; tc<=0 after its pulse; only load leaves.
- tc is high for exactly one cycle per expiry and is 0 on every non-expiry edge.
- prescale change mid-count: the new value is compared from the next edge. If pre_cnt>prescale, pre_cnt counts up and wraps modulo 2^PRE_W to 0 before it can match.
- auto_reload is sampled only on the expiry tick.
- running = (state==RUN); done = (state==EXPIRED); both registered with state.
- The counter never underflows: count 0 in RUN is unreachable.

## Timing
- All outputs change only on rising clk and are registered, with no combinational input-to-output paths.
- Load at edge N: count==load_value after N; running/done update at N.
- With enable held 1 from edge N+1, the tick period is prescale+1 cycles.
- tc asserts after edge N + load_value*(prescale+1) and deasserts one edge later.
- Auto-reload: the next tc follows exactly reload_reg*(prescale+1) enabled cycles later, giving a periodic pulse with no extra reload cycle.
- Reset mid-count takes effect at that edge: all outputs return to reset values, including an in-flight tc.
- Load coinciding with an expiry tick: load wins, tc stays 0, and count becomes load_value.
- Enable dropping on the tick cycle means no tick occurs; the tick fires on the next enabled cycle.

## Test plan
- Reset held 5 cycles, then release -> count=0, tc=0, running=0, done=0, state IDLE with enable=1 (no counting).
- load_value=5, prescale=0, auto_reload=0, enable=1 -> count 5,4,3,2,1,0 on successive edges; tc high for exactly the cycle count becomes 0; done=1; count then holds 0 for 10 cycles.
- load_value=3, prescale=2, auto_reload=1 -> tc pulses every 9 cycles for 4 periods; count sequence 3,3,3,2,2,2,1,1,1,3,...
- Enable toggled 1-in-2 with load_value=4, prescale=0 -> tc after 8 cycles; count is frozen on every enable=0 cycle.
- Load of 0x1234 on the cycle count==1 ticks -> no tc; count=0x1234, running=1. Separately, load_value=0 -> done=1 immediately and no tc.
- Reset asserted while count=0x0007 in RUN and again on a tc cycle -> next cycle all outputs are reset values and tc is 0.
